// File: rtl/ac_motor_sequencer.sv
// Start/stop sequencer for the AC motor drive: arms the gate drivers, ramps the
// power setpoint toward a target, ramps down on stop, and latches shoot-through faults.
module ac_motor_sequencer #(
  parameter int RAMP_DIV   = 1024,
  parameter int RAMP_STEP  = 1,
  parameter int ARM_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [11:0] target,
  input  logic        fault,
  input  logic        fault_clear,
  output logic [11:0] power,
  output logic        enable,
  output logic        at_target,
  output logic        fault_latched,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RAMP  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam int DIV_W = $clog2(RAMP_DIV + 1);
  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RAMP_DIV - 1);
  localparam logic [ARM_W-1:0] ARM_RELOAD = ARM_W'(ARM_CYCLES - 1);
  localparam logic [12:0]      STEP13     = 13'(RAMP_STEP);

  logic [2:0]       state_q, state_d;
  logic [11:0]      power_q, power_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic [12:0] pwr13, tgt13, diff13, ramp_amt, ramp13, down_amt, down13;
  logic        up, tick;

  function automatic logic [11:0] sat12(input logic [12:0] v);
    return (v > 13'd4095) ? 12'hFFF : v[11:0];
  endfunction

  // Step sizes are clamped so power lands exactly on target / zero.
  always_comb begin
    pwr13    = {1'b0, power_q};
    tgt13    = {1'b0, target};
    up       = tgt13 > pwr13;
    diff13   = up ? (tgt13 - pwr13) : (pwr13 - tgt13);
    ramp_amt = (diff13 < STEP13) ? diff13 : STEP13;
    ramp13   = up ? (pwr13 + ramp_amt) : (pwr13 - ramp_amt);
    down_amt = (pwr13 < STEP13) ? pwr13 : STEP13;
    down13   = pwr13 - down_amt;
    tick     = (div_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      power_q <= '0;
      arm_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      power_q <= power_d;
      arm_q   <= arm_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    power_d = power_q;
    arm_d   = arm_q;
    div_d   = div_q;
    if (fault) begin
      state_d = S_FAULT;
      power_d = '0;
      arm_d   = '0;
      div_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          power_d = '0;
          if (start && !stop) begin
            state_d = S_ARM;
            arm_d   = ARM_RELOAD;
          end
        end
        S_ARM: begin
          power_d = '0;
          if (stop) begin
            state_d = S_IDLE;
          end else if (arm_q == '0) begin
            state_d = S_RAMP;
            div_d   = DIV_RELOAD;
          end else begin
            arm_d = arm_q - 1'b1;
          end
        end
        S_RAMP: begin
          if (stop) begin
            state_d = S_STOP;
          end else if (power_q == target) begin
            state_d = S_RUN;
          end else if (tick) begin
            power_d = sat12(ramp13);
            div_d   = DIV_RELOAD;
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_STOP;
            div_d   = DIV_RELOAD;
          end else if (power_q != target) begin
            state_d = S_RAMP;
            div_d   = DIV_RELOAD;
          end
        end
        S_STOP: begin
          if (power_q == '0) begin
            state_d = S_IDLE;
          end else if (tick) begin
            power_d = sat12(down13);
            div_d   = DIV_RELOAD;
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        S_FAULT: begin
          power_d = '0;
          if (fault_clear) state_d = S_IDLE;
        end
        default: begin
          state_d = S_FAULT;
          power_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    power         = power_q;
    state         = state_q;
    enable        = (state_q == S_ARM) || (state_q == S_RAMP) ||
                    (state_q == S_RUN) || (state_q == S_STOP);
    at_target     = (state_q == S_RUN);
    fault_latched = (state_q == S_FAULT);
  end

endmodule

// File: tb/tb_ac_motor_sequencer.sv
// Directed bench for ac_motor_sequencer with RAMP_DIV=4, RAMP_STEP=16, ARM_CYCLES=8.
module tb_ac_motor_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, fault, fault_clear;
  logic [11:0] target;
  logic [11:0] power;
  logic        enable, at_target, fault_latched;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  ac_motor_sequencer #(.RAMP_DIV(4), .RAMP_STEP(16), .ARM_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .target(target),
    .fault(fault), .fault_clear(fault_clear), .power(power), .enable(enable),
    .at_target(at_target), .fault_latched(fault_latched), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [11:0] pw,
                         input logic en, input logic at, input logic fl);
    chk({tag, ".state"}, 16'(state), 16'(st));
    chk({tag, ".power"}, 16'(power), 16'(pw));
    chk({tag, ".enable"}, 16'(enable), 16'(en));
    chk({tag, ".at_target"}, 16'(at_target), 16'(at));
    chk({tag, ".fault_latched"}, 16'(fault_latched), 16'(fl));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clear = 1'b0;
    target = 12'd0;
    #12;
    chk_all("reset", 3'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cyc(1);
    chk_all("idle", 3'd0, 12'd0, 1'b0, 1'b0, 1'b0);

    // basic start to 64
    target = 12'd64; start = 1'b1;
    cyc(1);
    chk_all("arm_enter", 3'd1, 12'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    cyc(7);
    chk_all("arm_hold", 3'd1, 12'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("ramp_enter", 3'd2, 12'd0, 1'b1, 1'b0, 1'b0);
    cyc(3);
    chk("ramp_pre_tick", 16'(power), 16'd0);
    cyc(1);
    chk("ramp_16", 16'(power), 16'd16);
    cyc(4);
    chk("ramp_32", 16'(power), 16'd32);
    cyc(4);
    chk("ramp_48", 16'(power), 16'd48);
    cyc(4);
    chk_all("ramp_64", 3'd2, 12'd64, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("run_64", 3'd3, 12'd64, 1'b1, 1'b1, 1'b0);

    // controlled stop from 64
    stop = 1'b1;
    cyc(1);
    chk_all("stop_enter", 3'd4, 12'd64, 1'b1, 1'b0, 1'b0);
    stop = 1'b0;
    cyc(3);
    chk("stop_pre_tick", 16'(power), 16'd64);
    cyc(1);
    chk("stop_48", 16'(power), 16'd48);
    cyc(4);
    chk("stop_32", 16'(power), 16'd32);
    cyc(4);
    chk("stop_16", 16'(power), 16'd16);
    cyc(4);
    chk_all("stop_0", 3'd4, 12'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("stop_idle", 3'd0, 12'd0, 1'b0, 1'b0, 1'b0);

    // clamped step to 40, then retarget down to 8
    target = 12'd40; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    chk("clamp_ramp_state", 16'(state), 16'd2);
    cyc(4);
    chk("clamp_16", 16'(power), 16'd16);
    cyc(4);
    chk("clamp_32", 16'(power), 16'd32);
    cyc(4);
    chk("clamp_40", 16'(power), 16'd40);
    cyc(1);
    chk_all("clamp_run", 3'd3, 12'd40, 1'b1, 1'b1, 1'b0);
    target = 12'd8;
    cyc(1);
    chk_all("retarget_ramp", 3'd2, 12'd40, 1'b1, 1'b0, 1'b0);
    cyc(4);
    chk("down_24", 16'(power), 16'd24);
    cyc(4);
    chk("down_8", 16'(power), 16'd8);
    cyc(1);
    chk_all("down_run", 3'd3, 12'd8, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(4);
    chk_all("clamp_stop_0", 3'd4, 12'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk("clamp_stop_idle", 16'(state), 16'd0);

    // fault mid-ramp at 32
    target = 12'd64; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    cyc(8);
    chk_all("pre_fault", 3'd2, 12'd32, 1'b1, 1'b0, 1'b0);
    fault = 1'b1;
    cyc(1);
    chk_all("fault_hit", 3'd5, 12'd0, 1'b0, 1'b0, 1'b1);
    fault = 1'b0; start = 1'b1;
    cyc(1);
    chk_all("fault_start_ign", 3'd5, 12'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; fault = 1'b1; fault_clear = 1'b1;
    cyc(1);
    chk_all("fault_clear_ign", 3'd5, 12'd0, 1'b0, 1'b0, 1'b1);
    fault = 1'b0;
    cyc(1);
    chk_all("fault_released", 3'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    fault_clear = 1'b0;

    // asynchronous reset mid-ramp at 48
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    cyc(12);
    chk_all("pre_reset", 3'd2, 12'd48, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 3'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    cyc(1);
    chk_all("post_reset", 3'd0, 12'd0, 1'b0, 1'b0, 1'b0);

    // stop during ARM, start+stop in IDLE, then zero target
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk_all("arm_mid", 3'd1, 12'd0, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    cyc(1);
    chk_all("arm_stopped", 3'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc(1);
    chk("start_stop_idle", 16'(state), 16'd0);
    stop = 1'b0; target = 12'd0;
    cyc(1);
    chk("zero_arm", 16'(state), 16'd1);
    start = 1'b0;
    cyc(7);
    chk("zero_arm_hold", 16'(state), 16'd1);
    cyc(1);
    chk_all("zero_ramp", 3'd2, 12'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("zero_run", 3'd3, 12'd0, 1'b1, 1'b1, 1'b0);

    // fault from RUN
    fault = 1'b1;
    cyc(1);
    chk_all("run_fault", 3'd5, 12'd0, 1'b0, 1'b0, 1'b1);
    fault = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
